// File: rtl/sprite_line_engine.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_engine
// Description : Per-scanline sprite evaluation and pixel resolution. Scans
//               OAM for sprites intersecting the next line, fetches one
//               graphics row per hit into a pending bank, promotes it to the
//               active bank at the line boundary and emits a priority-resolved
//               sprite pixel per hcount.
//               Optional macro: SPRITE_COLLISION_EN (sticky sprite-sprite
//               overlap flag; when undefined, collision is tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_engine #(
  parameter int NUM_SLOTS   = 8,
  parameter int OAM_ENTRIES = 64,
  parameter int SPRITE_H    = 16,
  parameter int GFX_AW      = 11
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           line_start,
  input  logic [9:0]                     next_line,
  input  logic [10:0]                    hcount,
  output logic [$clog2(OAM_ENTRIES)-1:0] oam_addr,
  input  logic [31:0]                    oam_rdata,
  output logic [GFX_AW-1:0]              gfx_addr,
  input  logic [31:0]                    gfx_rdata,
  output logic [1:0]                     spr_pixel,
  output logic [1:0]                     spr_palette,
  output logic                           spr_behind,
  output logic                           busy,
  output logic                           overflow,
  output logic                           collision,
  input  logic                           collision_clr
);

  localparam int OAW   = $clog2(OAM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int DY_W  = $clog2(SPRITE_H);

  localparam logic [OAW:0]       c_scan_last = (OAW + 1)'(OAM_ENTRIES);
  localparam logic [CNT_W-1:0]   c_num_slots = CNT_W'(NUM_SLOTS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FETCH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Evaluation bookkeeping
  logic [9:0]       r_line;
  logic [OAW:0]     r_scan_cnt;   // SCAN cycle count; entry (cnt-1) is on oam_rdata
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_fetch_idx;
  logic             r_iss_v;      // gfx_addr currently presented is for r_iss_idx
  logic [IDX_W-1:0] r_iss_idx;
  logic             r_cap_v;      // gfx_rdata currently belongs to r_cap_idx
  logic [IDX_W-1:0] r_cap_idx;

  // Pending bank (being built for the next line)
  logic [9:0]       r_pend_x      [NUM_SLOTS];
  logic [DY_W-1:0]  r_pend_dy     [NUM_SLOTS];
  logic [7:0]       r_pend_tile   [NUM_SLOTS];
  logic [1:0]       r_pend_pal    [NUM_SLOTS];
  logic             r_pend_hflip  [NUM_SLOTS];
  logic             r_pend_behind [NUM_SLOTS];
  logic [31:0]      r_pend_row    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_pend_valid;

  // Active bank (drives the pixel path)
  logic [9:0]       r_act_x       [NUM_SLOTS];
  logic [1:0]       r_act_pal     [NUM_SLOTS];
  logic             r_act_hflip   [NUM_SLOTS];
  logic             r_act_behind  [NUM_SLOTS];
  logic [31:0]      r_act_row     [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_act_valid;

  // OAM entry decode; y is 9 bits, zero-extended for the 10-bit dy
  logic       w_en;
  logic [9:0] w_dy;
  logic       w_hit;
  logic       w_stop;
  logic       w_last;
  logic       w_fetch_issue;
  logic       w_fetch_done;
  logic [IDX_W-1:0] w_fi;

  assign w_en   = oam_rdata[31];
  assign w_dy   = r_line - {1'b0, oam_rdata[18:10]};
  assign w_hit  = (r_state == S_SCAN) && (r_scan_cnt != '0) && w_en &&
                  (w_dy < 10'(SPRITE_H));
  assign w_stop = w_hit && (r_hit_cnt == c_num_slots);
  assign w_last = (r_state == S_SCAN) && (r_scan_cnt == c_scan_last);

  assign w_fi          = r_fetch_idx[IDX_W-1:0];
  assign w_fetch_issue = (r_state == S_FETCH) && (r_fetch_idx < r_hit_cnt);
  // Leave FETCH in the same cycle the last row is captured
  assign w_fetch_done  = (r_state == S_FETCH) &&
                         ((r_hit_cnt == '0) ||
                          (r_cap_v && (CNT_W'(r_cap_idx) == r_hit_cnt - CNT_W'(1))));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; line_start always restarts the scan
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    case (r_state)
      S_IDLE:  ;
      S_SCAN: begin
        busy = 1'b1;
        if (w_stop || w_last) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy = 1'b1;
        if (w_fetch_done) w_state_nxt = S_DONE;
      end
      S_DONE:  ;
      default: w_state_nxt = S_IDLE;
    endcase
    if (line_start) w_state_nxt = S_SCAN;
  end

  // Scan, fetch and bank-swap datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oam_addr     <= '0;
      gfx_addr     <= '0;
      overflow     <= 1'b0;
      r_line       <= '0;
      r_scan_cnt   <= '0;
      r_hit_cnt    <= '0;
      r_fetch_idx  <= '0;
      r_iss_v      <= 1'b0;
      r_iss_idx    <= '0;
      r_cap_v      <= 1'b0;
      r_cap_idx    <= '0;
      r_pend_valid <= '0;
      r_act_valid  <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_pend_x[s]      <= '0;
        r_pend_dy[s]     <= '0;
        r_pend_tile[s]   <= '0;
        r_pend_pal[s]    <= '0;
        r_pend_hflip[s]  <= 1'b0;
        r_pend_behind[s] <= 1'b0;
        r_pend_row[s]    <= '0;
        r_act_x[s]       <= '0;
        r_act_pal[s]     <= '0;
        r_act_hflip[s]   <= 1'b0;
        r_act_behind[s]  <= 1'b0;
        r_act_row[s]     <= '0;
      end
    end else if (line_start) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_act_x[s]      <= r_pend_x[s];
        r_act_pal[s]    <= r_pend_pal[s];
        r_act_hflip[s]  <= r_pend_hflip[s];
        r_act_behind[s] <= r_pend_behind[s];
        r_act_row[s]    <= r_pend_row[s];
      end
      // An interrupted evaluation yields an empty line and flags overflow
      r_act_valid  <= busy ? '0 : r_pend_valid;
      overflow     <= busy;
      r_pend_valid <= '0;
      r_line       <= next_line;
      oam_addr     <= '0;
      r_scan_cnt   <= '0;
      r_hit_cnt    <= '0;
      r_fetch_idx  <= '0;
      r_iss_v      <= 1'b0;
      r_cap_v      <= 1'b0;
    end else begin
      if (r_state == S_SCAN) begin
        oam_addr   <= oam_addr + OAW'(1);
        r_scan_cnt <= r_scan_cnt + (OAW + 1)'(1);
      end
      if (w_hit) begin
        if (w_stop) begin
          overflow <= 1'b1;
        end else begin
          r_pend_x[r_hit_cnt[IDX_W-1:0]]      <= oam_rdata[9:0];
          r_pend_dy[r_hit_cnt[IDX_W-1:0]]     <= w_dy[DY_W-1:0];
          r_pend_tile[r_hit_cnt[IDX_W-1:0]]   <= oam_rdata[26:19];
          r_pend_pal[r_hit_cnt[IDX_W-1:0]]    <= oam_rdata[28:27];
          r_pend_hflip[r_hit_cnt[IDX_W-1:0]]  <= oam_rdata[29];
          r_pend_behind[r_hit_cnt[IDX_W-1:0]] <= oam_rdata[30];
          r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
      end
      r_iss_v <= w_fetch_issue;
      if (w_fetch_issue) begin
        gfx_addr    <= GFX_AW'(r_pend_tile[w_fi]) * GFX_AW'(SPRITE_H) +
                       GFX_AW'(r_pend_dy[w_fi]);
        r_iss_idx   <= w_fi;
        r_fetch_idx <= r_fetch_idx + CNT_W'(1);
      end
      r_cap_v   <= r_iss_v;
      r_cap_idx <= r_iss_idx;
      if (r_cap_v) begin
        r_pend_row[r_cap_idx]   <= gfx_rdata;
        r_pend_valid[r_cap_idx] <= 1'b1;
      end
    end
  end

  // Per-slot pixel lookup; off wraps in 11 bits so a sprite never wraps to column 0
  logic [1:0] w_slot_pix [NUM_SLOTS];

  generate
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      logic [10:0] w_off;
      logic [3:0]  w_idx;
      assign w_off = hcount - {1'b0, r_act_x[s]};
      assign w_idx = r_act_hflip[s] ? (4'd15 - w_off[3:0]) : w_off[3:0];
      assign w_slot_pix[s] = (r_act_valid[s] && (w_off < 11'd16)) ?
                             r_act_row[s][{w_idx, 1'b0} +: 2] : 2'b00;
    end
  endgenerate

  logic [1:0] w_win_pix;
  logic [1:0] w_win_pal;
  logic       w_win_behind;

  // Lowest-numbered opaque slot wins, so scan from the top down
  always_comb begin
    w_win_pix    = 2'b00;
    w_win_pal    = 2'b00;
    w_win_behind = 1'b0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (w_slot_pix[s] != 2'b00) begin
        w_win_pix    = w_slot_pix[s];
        w_win_pal    = r_act_pal[s];
        w_win_behind = r_act_behind[s];
      end
    end
  end

  // Registered pixel outputs, one cycle behind hcount
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spr_pixel   <= 2'b00;
      spr_palette <= 2'b00;
      spr_behind  <= 1'b0;
    end else begin
      spr_pixel   <= w_win_pix;
      spr_palette <= w_win_pal;
      spr_behind  <= w_win_behind;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic w_multi;
  logic w_seen;

  // Flag any column where two or more slots are opaque
  always_comb begin
    w_multi = 1'b0;
    w_seen  = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (w_slot_pix[s] != 2'b00) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

  // Sticky collision flag; clear beats a simultaneous set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             collision <= 1'b0;
    else if (collision_clr) collision <= 1'b0;
    else if (w_multi)       collision <= 1'b1;
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = collision_clr;
  assign collision    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_line_engine
// Description : Directed self-checking bench for sprite_line_engine with
//               behavioural OAM and sprite_graphics memories (1-cycle read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_line_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [9:0]  next_line;
  logic [10:0] hcount;
  logic [5:0]  oam_addr;
  logic [31:0] oam_rdata;
  logic [10:0] gfx_addr;
  logic [31:0] gfx_rdata;
  logic [1:0]  spr_pixel;
  logic [1:0]  spr_palette;
  logic        spr_behind;
  logic        busy;
  logic        overflow;
  logic        collision;
  logic        collision_clr;

  logic [31:0] oam_mem [64];
  logic [31:0] gfx_mem [2048];

  int total;
  int bad;

`ifdef SPRITE_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  sprite_line_engine #(
    .NUM_SLOTS   (8),
    .OAM_ENTRIES (64),
    .SPRITE_H    (16),
    .GFX_AW      (11)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .line_start    (line_start),
    .next_line     (next_line),
    .hcount        (hcount),
    .oam_addr      (oam_addr),
    .oam_rdata     (oam_rdata),
    .gfx_addr      (gfx_addr),
    .gfx_rdata     (gfx_rdata),
    .spr_pixel     (spr_pixel),
    .spr_palette   (spr_palette),
    .spr_behind    (spr_behind),
    .busy          (busy),
    .overflow      (overflow),
    .collision     (collision),
    .collision_clr (collision_clr)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data appears the cycle after the address
  always @(posedge clk) begin
    oam_rdata <= oam_mem[oam_addr];
    gfx_rdata <= gfx_mem[gfx_addr];
  end

  function automatic logic [31:0] mk(input logic en, input logic behind,
                                     input logic hflip, input logic [1:0] pal,
                                     input logic [7:0] tile, input logic [8:0] y,
                                     input logic [9:0] x);
    return {en, behind, hflip, pal, tile, y, x};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++)   oam_mem[i] = 32'h0;
    for (int i = 0; i < 2048; i++) gfx_mem[i] = 32'h0;
  endtask

  task automatic pulse_ls(input logic [9:0] l);
    @(negedge clk);
    line_start = 1'b1;
    next_line  = l;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic probe(input logic [10:0] h, input logic clr);
    @(negedge clk);
    hcount        = h;
    collision_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int nz;
    total++;
    if ({busy, overflow, collision, spr_pixel, spr_palette, spr_behind, oam_addr, gfx_addr} !== 32'h0) begin
      bad++;
      $display("FAIL reset_values: got busy=%b ovf=%b col=%b pix=%0d pal=%0d beh=%b oam=%0d gfx=%0d, required all 0",
               busy, overflow, collision, spr_pixel, spr_palette, spr_behind, oam_addr, gfx_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_mem();
    oam_mem[3] = mk(1, 0, 0, 2'd2, 8'd5, 9'd100, 10'd200);
    gfx_mem[83] = 32'h0000000C;
    for (int i = 0; i < 9; i++) oam_mem[10+i] = mk(1, 0, 0, 2'd0, 8'd0, 9'd100, 10'd400);
    pulse_ls(10'd103);
    wait_idle();
    pulse_ls(10'd103);
    hcount = 11'd201;
    repeat (22) @(negedge clk);
    total++;
    if (busy !== 1'b1 || overflow !== 1'b1 || spr_pixel !== 2'd3) begin
      bad++;
      $display("FAIL pre_reset: got busy=%b ovf=%b pix=%0d, required busy=1 ovf=1 pix=3", busy, overflow, spr_pixel);
    end
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || overflow !== 1'b0 || spr_pixel !== 2'd0 || oam_addr !== 6'd0 || gfx_addr !== 11'd0) begin
      bad++;
      $display("FAIL midscan_reset: got busy=%b ovf=%b pix=%0d oam=%0d gfx=%0d, required all 0",
               busy, overflow, spr_pixel, oam_addr, gfx_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    nz = 0;
    for (int h = 0; h < 640; h++) begin
      probe(11'(h), 1'b0);
      if (spr_pixel !== 2'd0) nz++;
    end
    total++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL post_reset_sweep: %0d nonzero pixels, required 0", nz);
    end
  endtask

  task automatic test_basic();
    clear_mem();
    oam_mem[3]  = mk(1, 0, 0, 2'd2, 8'd5, 9'd100, 10'd200);
    gfx_mem[83] = 32'h0000000C;
    oam_mem[5]  = mk(1, 0, 0, 2'd0, 8'd6, 9'd100, 10'd630);
    gfx_mem[99] = 32'hAAAAAAAA;
    oam_mem[63] = mk(1, 0, 0, 2'd1, 8'd7, 9'd100, 10'd500);
    gfx_mem[115] = 32'h00000001;
    pulse_ls(10'd103);
    wait_idle();
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL basic_overflow: got %b, required 0", overflow);
    end
    pulse_ls(10'd104);
    wait_idle();
    probe(11'd201, 1'b0);
    total++;
    if ({spr_pixel, spr_palette, spr_behind} !== {2'd3, 2'd2, 1'b0}) begin
      bad++;
      $display("FAIL basic_201: got pix=%0d pal=%0d beh=%b, required pix=3 pal=2 beh=0", spr_pixel, spr_palette, spr_behind);
    end
    probe(11'd200, 1'b0);
    total++;
    if ({spr_pixel, spr_palette, spr_behind} !== 5'd0) begin
      bad++;
      $display("FAIL basic_200: got pix=%0d pal=%0d, required 0 0", spr_pixel, spr_palette);
    end
    probe(11'd202, 1'b0);
    total++;
    if (spr_pixel !== 2'd0) begin
      bad++;
      $display("FAIL basic_202: got pix=%0d, required 0", spr_pixel);
    end
    probe(11'd500, 1'b0);
    total++;
    if ({spr_pixel, spr_palette} !== {2'd1, 2'd1}) begin
      bad++;
      $display("FAIL last_entry_500: got pix=%0d pal=%0d, required pix=1 pal=1", spr_pixel, spr_palette);
    end
    probe(11'd630, 1'b0);
    total++;
    if ({spr_pixel, spr_palette} !== {2'd2, 2'd0}) begin
      bad++;
      $display("FAIL clip_630: got pix=%0d pal=%0d, required pix=2 pal=0", spr_pixel, spr_palette);
    end
    probe(11'd639, 1'b0);
    total++;
    if (spr_pixel !== 2'd2) begin
      bad++;
      $display("FAIL clip_639: got pix=%0d, required 2", spr_pixel);
    end
    probe(11'd0, 1'b0);
    total++;
    if (spr_pixel !== 2'd0) begin
      bad++;
      $display("FAIL nowrap_0: got pix=%0d, required 0", spr_pixel);
    end
    probe(11'd5, 1'b0);
    total++;
    if (spr_pixel !== 2'd0) begin
      bad++;
      $display("FAIL nowrap_5: got pix=%0d, required 0", spr_pixel);
    end
  endtask

  task automatic test_hflip();
    clear_mem();
    oam_mem[3]  = mk(1, 1, 1, 2'd2, 8'd5, 9'd100, 10'd200);
    gfx_mem[83] = 32'h0000000C;
    pulse_ls(10'd103);
    wait_idle();
    pulse_ls(10'd104);
    wait_idle();
    probe(11'd214, 1'b0);
    total++;
    if ({spr_pixel, spr_palette, spr_behind} !== {2'd3, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL hflip_214: got pix=%0d pal=%0d beh=%b, required pix=3 pal=2 beh=1", spr_pixel, spr_palette, spr_behind);
    end
    probe(11'd201, 1'b0);
    total++;
    if (spr_pixel !== 2'd0) begin
      bad++;
      $display("FAIL hflip_201: got pix=%0d, required 0", spr_pixel);
    end
    probe(11'd200, 1'b0);
    total++;
    if (spr_pixel !== 2'd0) begin
      bad++;
      $display("FAIL hflip_200: got pix=%0d, required 0", spr_pixel);
    end
  endtask

  task automatic test_overflow();
    logic [4:0] exp;
    clear_mem();
    for (int i = 0; i < 8; i++) begin
      oam_mem[i] = mk(1, 0, 0, 2'(i % 4), 8'(i + 1), 9'd50, 10'(20 * i + 10));
      gfx_mem[(i + 1) * 16] = 32'h00000001;
    end
    pulse_ls(10'd50);
    wait_idle();
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL exact_fit_overflow: got %b, required 0", overflow);
    end
    for (int i = 8; i < 10; i++) begin
      oam_mem[i] = mk(1, 0, 0, 2'(i % 4), 8'(i + 1), 9'd50, 10'(20 * i + 10));
      gfx_mem[(i + 1) * 16] = 32'h00000001;
    end
    pulse_ls(10'd50);
    wait_idle();
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ten_hits_overflow: got %b, required 1", overflow);
    end
    pulse_ls(10'd51);
    wait_idle();
    for (int i = 0; i < 10; i++) begin
      probe(11'(20 * i + 10), 1'b0);
      exp = (i < 8) ? {2'd1, 2'(i % 4), 1'b0} : 5'd0;
      total++;
      if ({spr_pixel, spr_palette, spr_behind} !== exp) begin
        bad++;
        $display("FAIL overflow_slot%0d: got pix=%0d pal=%0d, required pix=%0d pal=%0d",
                 i, spr_pixel, spr_palette, exp[4:3], exp[2:1]);
      end
    end
  endtask

  task automatic test_priority();
    clear_mem();
    oam_mem[0]   = mk(1, 0, 0, 2'd1, 8'd10, 9'd20, 10'd300);
    oam_mem[1]   = mk(1, 0, 0, 2'd3, 8'd11, 9'd20, 10'd300);
    gfx_mem[160] = 32'h00000002;
    gfx_mem[176] = 32'h0000000D;
    pulse_ls(10'd20);
    wait_idle();
    pulse_ls(10'd21);
    wait_idle();
    probe(11'd300, 1'b0);
    total++;
    if ({spr_pixel, spr_palette, collision} !== {2'd2, 2'd1, COLL_EN}) begin
      bad++;
      $display("FAIL prio_300: got pix=%0d pal=%0d col=%b, required pix=2 pal=1 col=%b", spr_pixel, spr_palette, collision, COLL_EN);
    end
    probe(11'd301, 1'b0);
    total++;
    if ({spr_pixel, spr_palette, collision} !== {2'd3, 2'd3, COLL_EN}) begin
      bad++;
      $display("FAIL prio_301: got pix=%0d pal=%0d col=%b, required pix=3 pal=3 col=%b", spr_pixel, spr_palette, collision, COLL_EN);
    end
    probe(11'd301, 1'b1);
    total++;
    if (collision !== 1'b0) begin
      bad++;
      $display("FAIL coll_clear: got %b, required 0", collision);
    end
    probe(11'd300, 1'b1);
    total++;
    if (collision !== 1'b0) begin
      bad++;
      $display("FAIL coll_clr_priority: got %b, required 0", collision);
    end
    probe(11'd300, 1'b0);
    total++;
    if (collision !== COLL_EN) begin
      bad++;
      $display("FAIL coll_reset: got %b, required %b", collision, COLL_EN);
    end
    probe(11'd0, 1'b1);
    probe(11'd0, 1'b0);
  endtask

  task automatic test_abort();
    clear_mem();
    oam_mem[3]  = mk(1, 0, 0, 2'd2, 8'd5, 9'd100, 10'd200);
    gfx_mem[83] = 32'h0000000C;
    pulse_ls(10'd103);
    wait_idle();
    pulse_ls(10'd103);
    repeat (8) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_precond_busy: got %b, required 1", busy);
    end
    pulse_ls(10'd103);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL abort_overflow: got %b, required 1", overflow);
    end
    probe(11'd201, 1'b0);
    total++;
    if (spr_pixel !== 2'd0) begin
      bad++;
      $display("FAIL abort_empty_bank: got pix=%0d, required 0", spr_pixel);
    end
    wait_idle();
    probe(11'd201, 1'b0);
    total++;
    if (spr_pixel !== 2'd0 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL abort_line_after_scan: got pix=%0d ovf=%b, required pix=0 ovf=1", spr_pixel, overflow);
    end
    pulse_ls(10'd104);
    wait_idle();
    probe(11'd201, 1'b0);
    total++;
    if ({spr_pixel, spr_palette, overflow} !== {2'd3, 2'd2, 1'b0}) begin
      bad++;
      $display("FAIL abort_recovery: got pix=%0d pal=%0d ovf=%b, required pix=3 pal=2 ovf=0", spr_pixel, spr_palette, overflow);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b0;
    line_start    = 1'b0;
    next_line     = 10'd0;
    hcount        = 11'd0;
    collision_clr = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_hflip();
    test_overflow();
    test_priority();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_line_engine.md
Name: sprite_line_engine

Overview:
- Parametrised successor to the fixed 8-slot sprite shift-register and priority-encoder path in the PPU.
- For each scanline, scans OAM for sprites that intersect the next line and fetches one graphics row per selected sprite into a pending bank.
- On the next line boundary, promotes the pending bank to an active bank.
- While the line is displayed, emits a priority-resolved sprite pixel for each hcount.
- Sits between the OAM/sprite_graphics memories and the pixel compositor in the PPU.

Parameters:
- NUM_SLOTS, 8, sprites displayable per line (1..16).
- OAM_ENTRIES, 64, OAM words scanned per line (power of 2, at most 256).
- SPRITE_H, 16, sprite height in rows (power of 2, 8 or 16).
- GFX_AW, 11, sprite_graphics word address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle pulse at the start of each line's hblank.
- next_line  in  10  line to evaluate; sampled on line_start.
- hcount  in  11  current pixel column of the active line.
- oam_addr  out  $clog2(OAM_ENTRIES)  OAM read address.
- oam_rdata  in  32  OAM word; valid 1 cycle after oam_addr.
- gfx_addr  out  GFX_AW  sprite_graphics read address.
- gfx_rdata  in  32  16 pixels x 2bpp; pixel p is bits [2p+1:2p]; valid 1 cycle after gfx_addr.
- spr_pixel  out  2  resolved sprite pixel index; 0 means transparent.
- spr_palette  out  2  palette of the winning sprite.
- spr_behind  out  1  winning sprite's behind-background bit.
- busy  out  1  evaluation in progress.
- overflow  out  1  more than NUM_SLOTS hits on the last evaluation, or evaluation aborted.
- collision  out  1  sticky sprite-sprite overlap (see Optional Feature).
- collision_clr  in  1  clears collision.

Behaviour:
- OAM word fields:
  - [9:0] x
  - [18:10] y
  - [26:19] tile
  - [28:27] palette
  - [29] hflip
  - [30] behind
  - [31] enable
- Reset (asynchronous, active-low):
  - FSM returns to IDLE.
  - All pending and active slot valid bits cleared.
  - All outputs 0; oam_addr and gfx_addr are 0.
- FSM states: IDLE, SCAN, FETCH, DONE.
  - IDLE --line_start--> SCAN.
  - SCAN --last entry checked, or (NUM_SLOTS+1)th hit--> FETCH.
  - FETCH --all hit slots fetched--> DONE.
  - DONE --line_start--> SCAN.
- On every line_start:
  - Pending bank is copied to the active bank.
  - Pending bank is cleared.
  - next_line is latched.
  - oam_addr is set to 0.
  - overflow is cleared.
- SCAN:
  - oam_addr increments by 1 each cycle; it is pipelined against the 1-cycle read latency.
  - Entry hits when enable=1 and dy=(next_line - y), computed in 10-bit unsigned, satisfies dy < SPRITE_H.
  - Hits fill slots 0,1,2,... in OAM index order, storing x, dy, tile, palette, hflip and behind.
  - On the (NUM_SLOTS+1)th hit: overflow=1, and scanning stops immediately.
- FETCH:
  - For each hit slot in order, gfx_addr = (tile*SPRITE_H + dy) truncated to GFX_AW.
  - Row data is captured 1 cycle later; one address is issued per cycle.
  - Slot valid bit is set when its row is captured.
- busy=1 in SCAN and FETCH.
- Worst case is OAM_ENTRIES + NUM_SLOTS + 3 cycles after line_start; this must fit in one line period.
- line_start while busy:
  - Current evaluation is aborted.
  - Active bank receives an empty set (all invalid).
  - overflow=1.
  - New scan starts.
- Pixel path, for each valid active slot:
  - off = hcount - x, computed in 11 bits.
  - Slot covers the pixel when off < 16.
  - Pixel index is off when hflip=0, or 15-off when hflip=1.
  - Among covering slots with a nonzero pixel, the lowest slot number wins.
- Outputs spr_pixel, spr_palette and spr_behind are registered: 1 cycle latency from hcount.
- No winner: spr_pixel=0, spr_palette=0, spr_behind=0.
- Sprite at x=630 clips naturally at the line end; there is no wrap to column 0.

Optional Feature:
- Macro SPRITE_COLLISION_EN.
- Defined:
  - collision is set the cycle after any hcount where two or more active slots produce nonzero pixels.
  - It stays set until collision_clr=1.
  - collision_clr has priority over a simultaneous set.
- Undefined: collision is constant 0, collision_clr is ignored, and no compare logic is built.

Test Plan:
1. Reset held low mid-SCAN -> busy=0, spr_pixel=0, overflow=0. After release, hcount sweep outputs only 0.
2. OAM[3] = {en=1, y=100, x=200, tile=5, pal=2, hflip=0}, next_line=103, sprite_graphics[83]=0x0000000C; line_start, then second line_start; hcount=201 -> next cycle spr_pixel=3, spr_palette=2. hcount=200 -> spr_pixel=0.
3. Same setup as scenario 2 with hflip=1 -> pixel appears at hcount=214, not 201.
4. Ten enabled sprites all at y=50, next_line=50, NUM_SLOTS=8 -> overflow=1. Only OAM entries 0..7 are displayed. Entries 8 and 9 are absent.
5. Slots 0 and 1 both nonzero at x=300 -> slot 0 palette wins. With SPRITE_COLLISION_EN defined: collision=1 until collision_clr pulse. Without the macro: collision stays 0.
6. line_start issued 10 cycles after the previous line_start (busy=1) -> overflow=1, active bank empty, all spr_pixel=0 for that line, new scan completes normally.
